gate_truth_sequencer: RTL and testbench

- Stimulus-and-check stage for a 2-input combinational gate (e.g. nor_gate) in synthesizable, clocked form.
- Upstream role: drives the gate inputs a/b through all four combinations, holding each for a fixed number of cycles.
- Downstream role: samples the gate output c, compares it against a parameterised expected truth table, and reports pass/fail, a per-combination fail vector and an error count.
- Used as an on-chip self-test wrapper around each DAY1 gate.

---
 rtl/gate_truth_sequencer.sv | 138 +++++++++++++
 tb/tb_gate_truth_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_sequencer.sv
// Self-test sequencer for a 2-input gate: sweeps {a,b} through 00..11, samples c
// against EXP_TABLE, and reports pass / per-combination fail vector / error count.
// Optional build macro GATE_SEQ_LOOP_EN: holding start at the end of a sweep
// restarts it immediately and accumulates results across sweeps.
//
// state | meaning
// IDLE  | waiting for start; results and last {a,b} held
// RUN   | sweeping combinations, sampling c in the last held cycle
// DONE  | one-cycle done pulse, then back to IDLE
module gate_truth_sequencer #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter logic [3:0]  EXP_TABLE   = 4'b0001
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       c,
   output logic       a,
   output logic       b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] fail_vec
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

   state_t     state, state_nxt;
   logic [1:0] idx, idx_nxt;
   logic [3:0] hold_cnt, hold_nxt;
   logic       busy_nxt, done_nxt, pass_nxt;
   logic [2:0] err_nxt;
   logic [3:0] fail_nxt;
   logic       sample;
   logic       miss;
   logic       wrap;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= 2'd0;
         hold_cnt  <= 4'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= 3'd0;
         fail_vec  <= 4'd0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         hold_cnt  <= hold_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         pass      <= pass_nxt;
         err_count <= err_nxt;
         fail_vec  <= fail_nxt;
      end
   end

   assign sample = (hold_cnt == HOLD_LAST);
   assign miss   = (c != EXP_TABLE[idx]);

`ifdef GATE_SEQ_LOOP_EN
   assign wrap = start;
`else
   assign wrap = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      hold_nxt  = hold_cnt;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      pass_nxt  = pass;
      err_nxt   = err_count;
      fail_nxt  = fail_vec;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
               idx_nxt   = 2'd0;
               hold_nxt  = 4'd0;
               busy_nxt  = 1'b1;
               pass_nxt  = 1'b0;
               err_nxt   = 3'd0;
               fail_nxt  = 4'd0;
            end
         end

         RUN: begin
            hold_nxt = hold_cnt + 4'd1;
            if (sample) begin
               // saturating add only matters when sweeps accumulate back to back
               if (miss) begin
                  fail_nxt[idx] = 1'b1;
                  if (err_count != 3'd7)
                     err_nxt = err_count + 3'd1;
               end
               hold_nxt = 4'd0;
               if (idx != 2'd3) begin
                  idx_nxt = idx + 2'd1;
               end else if (wrap) begin
                  idx_nxt  = 2'd0;
                  done_nxt = 1'b1;
                  pass_nxt = (err_nxt == 3'd0);
               end else begin
                  state_nxt = DONE;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  pass_nxt  = (err_nxt == 3'd0);
               end
            end
         end

         DONE: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   assign a = idx[1];
   assign b = idx[0];

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Directed bench for gate_truth_sequencer: a behavioural gate model drives c, and
// per-cycle expectations are queued when a sweep starts and popped as it runs.
module tb_gate_truth_sequencer;

   localparam int         H   = 4;
   localparam logic [3:0] EXP = 4'b0001;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       c;
   logic       a, b, busy, done, pass;
   logic [2:0] err_count;
   logic [3:0] fail_vec;

   int checks = 0;
   int errors = 0;
   int gate_mode = 0;   // 0 NOR, 1 tied 0, 2 OR, 3 tied 1

   typedef struct packed {
      logic [1:0] ab;
      logic       busy;
      logic       done;
   } cyc_t;

   typedef struct packed {
      logic       pass;
      logic [2:0] err;
      logic [3:0] fv;
   } res_t;

   cyc_t q[$];
   res_t rq[$];

   gate_truth_sequencer #(.HOLD_CYCLES(H), .EXP_TABLE(EXP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .c         (c),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_vec  (fail_vec)
   );

   always #5 clk = ~clk;

   function automatic logic gate_model(input int mode, input logic [1:0] ab);
      case (mode)
         0:       return (ab == 2'b00);
         1:       return 1'b0;
         2:       return (ab != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

   always_comb c = gate_model(gate_mode, {a, b});

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_results(input string tag, input res_t r);
      check({tag, "_pass"}, {7'd0, pass}, {7'd0, r.pass});
      check({tag, "_err"}, {5'd0, err_count}, {5'd0, r.err});
      check({tag, "_fvec"}, {4'd0, fail_vec}, {4'd0, r.fv});
   endtask

   // One full sweep; repulse re-asserts start mid-sweep, abort_at >= 0 resets at that cycle.
   task automatic run_sweep(input int mode, input bit repulse, input int abort_at);
      res_t r;
      cyc_t e;
      int   n;
      gate_mode = mode;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         if (gate_model(mode, 2'(i)) != EXP[i]) begin
            r.fv[i] = 1'b1;
            r.err   = r.err + 3'd1;
         end
      end
      r.pass = (r.err == 3'd0);
      for (int j = 0; j < 4 * H; j++) q.push_back('{ab: 2'(j / H), busy: 1'b1, done: 1'b0});
      q.push_back('{ab: 2'b11, busy: 1'b0, done: 1'b1});
      q.push_back('{ab: 2'b11, busy: 1'b0, done: 1'b0});
      rq.push_back(r);
      n = q.size();

      @(negedge clk) start = 1'b1;
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         start = (repulse && (j == 3 || j == 9)) ? 1'b1 : 1'b0;
         if (j == abort_at) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check("abort_outs", {a, b, busy, done, pass, err_count},
                  8'd0);
            check("abort_fvec", {4'd0, fail_vec}, 8'd0);
            for (int k = 0; k < 4 * H + 2; k++) begin
               @(negedge clk);
               check("abort_nodone", {6'd0, busy, done}, 8'd0);
            end
            q.delete();
            rq.delete();
            return;
         end
         e = q.pop_front();
         check($sformatf("ab_c%0d", j), {6'd0, a, b}, {6'd0, e.ab});
         check($sformatf("busy_c%0d", j), {7'd0, busy}, {7'd0, e.busy});
         check($sformatf("done_c%0d", j), {7'd0, done}, {7'd0, e.done});
         if (e.done) check_results("sweep", rq.pop_front());
      end
      @(negedge clk);
      check_results("held", r);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_outs", {a, b, busy, done, pass, err_count}, 8'd0);
      check("rst_fvec", {4'd0, fail_vec}, 8'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_sweep(0, 1'b0, -1);  // correct NOR
      run_sweep(1, 1'b0, -1);  // c stuck at 0
      run_sweep(2, 1'b0, -1);  // OR instead of NOR
      run_sweep(0, 1'b0, -1);  // recovers to pass
      run_sweep(2, 1'b1, -1);  // start re-pulsed mid-sweep
      run_sweep(0, 1'b0, 6);   // reset mid-sweep

`ifdef GATE_SEQ_LOOP_EN
      begin
         cyc_t e;
         logic [2:0] exp_err;
         int   n_done;
         gate_mode = 3;
         exp_err   = 3'd0;
         n_done    = 0;
         for (int j = 0; j < 12 * H + 2; j++) begin
            if (j < 12 * H)
               q.push_back('{ab: 2'((j % (4 * H)) / H), busy: 1'b1,
                             done: ((j % (4 * H)) == 0) && (j > 0)});
            else
               q.push_back('{ab: 2'b11, busy: 1'b0, done: (j == 12 * H)});
         end
         @(negedge clk) start = 1'b1;
         for (int j = 0; j < 12 * H + 2; j++) begin
            @(negedge clk);
            if (j == 8 * H + 1) start = 1'b0;
            e = q.pop_front();
            check($sformatf("loop_ab_c%0d", j), {6'd0, a, b}, {6'd0, e.ab});
            check($sformatf("loop_busy_c%0d", j), {7'd0, busy}, {7'd0, e.busy});
            check($sformatf("loop_done_c%0d", j), {7'd0, done}, {7'd0, e.done});
            if (e.done) begin
               n_done++;
               exp_err = (n_done == 1) ? 3'd3 : 3'd7 - ((n_done == 2) ? 3'd1 : 3'd0);
               check("loop_err", {5'd0, err_count}, {5'd0, exp_err});
               check("loop_pass", {7'd0, pass}, 8'd0);
            end
         end
         check("loop_ndone", 8'(n_done), 8'd3);
         check("loop_fvec", {4'd0, fail_vec}, 8'b0000_1110);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
